// File: rtl/bus_arb_pkg.sv
// Shared types for the N-master bus arbiter.
// Arbiter state encoding and arbitration mode constants.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        GRANT       = 2'd1,
        GRANT_SPLIT = 2'd2
    } arb_state_e;

    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Rotating-base priority picker: lowest index in fixed mode,
// first eligible index above base (mod N) in round-robin mode.
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  elig_i,
    input  logic [IW-1:0] base_i,
    input  logic          mode_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    logic [IW-1:0] cand;
    int            slot;

    // Walk from the furthest slot back to the nearest so the nearest wins.
    always_comb begin
        valid_o = |elig_i;
        idx_o   = '0;
        cand    = '0;
        slot    = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mode_i == ARB_RR) begin
                slot = (int'(base_i) + 1 + i) % N;
            end else begin
                slot = i;
            end
            cand = IW'(slot);
            if (elig_i[cand]) begin
                idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// N-master bus arbiter with fixed/round-robin pick, split masking
// and hold-time preemption; the split slave always wins from IDLE.
module bus_arbiter_rr
    import bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int RR_MODE     = 1,
    parameter int MAX_HOLD    = 0,
    parameter int SEL_W       = $clog2(NUM_MASTERS + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_MASTERS-1:0]         req_i,
    input  logic                           req_split_i,
    input  logic                           split_start_i,
    input  logic                           split_clr_i,
    input  logic [$clog2(NUM_MASTERS)-1:0] split_clr_id_i,
    output logic [NUM_MASTERS-1:0]         grant_o,
    output logic                           grant_split_o,
    output logic [SEL_W-1:0]               sel_o,
    output logic [NUM_MASTERS-1:0]         split_mask_o
);

    localparam int   IW         = $clog2(NUM_MASTERS);
    localparam int   HOLD_W     = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int   HOLD_LIM   = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
    localparam logic PREEMPT_EN = (RR_MODE == 1) && (MAX_HOLD != 0);
    localparam logic MODE       = (RR_MODE == 1) ? ARB_RR : ARB_FIXED;

    arb_state_e             state_q, state_d;
    logic [IW-1:0]          owner_q, owner_d;
    logic [IW-1:0]          ptr_q, ptr_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [NUM_MASTERS-1:0] mask_q, mask_d;

    logic [NUM_MASTERS-1:0] elig;
    logic [NUM_MASTERS-1:0] owner_oh;
    logic [NUM_MASTERS-1:0] others;
    logic                   hold_top;
    logic                   pick_valid;
    logic [IW-1:0]          pick_idx;

    assign elig     = req_i & ~mask_q;
    assign owner_oh = NUM_MASTERS'(1) << owner_q;
    assign others   = elig & ~owner_oh;
    assign hold_top = (hold_q == HOLD_W'(HOLD_LIM));

    rr_pick #(
        .N  (NUM_MASTERS),
        .IW (IW)
    ) u_pick (
        .elig_i  (elig),
        .base_i  (ptr_q),
        .mode_i  (MODE),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        mask_d  = mask_q;
        if (split_clr_i && (int'(split_clr_id_i) < NUM_MASTERS)) begin
            mask_d[split_clr_id_i] = 1'b0;
        end
        unique case (state_q)
            IDLE: begin
                if (req_split_i) begin
                    state_d = GRANT_SPLIT;
                end else if (pick_valid) begin
                    state_d = GRANT;
                    owner_d = pick_idx;
                    ptr_d   = pick_idx;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                // A split set is applied after the clear so it wins.
                if (split_start_i) begin
                    mask_d[owner_q] = 1'b1;
                    state_d         = IDLE;
                end else if (!req_i[owner_q]) begin
                    state_d = IDLE;
                end else if (PREEMPT_EN && hold_top && (|others)) begin
                    state_d = IDLE;
                end else if (!hold_top) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            GRANT_SPLIT: begin
                if (!req_split_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= IW'(NUM_MASTERS - 1);
            hold_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        grant_o       = '0;
        grant_split_o = 1'b0;
        sel_o         = '0;
        unique case (1'b1)
            (state_q == GRANT): begin
                grant_o = owner_oh;
                sel_o   = SEL_W'(owner_q) + SEL_W'(1);
            end
            (state_q == GRANT_SPLIT): grant_split_o = 1'b1;
            default: ;
        endcase
    end

    assign split_mask_o = mask_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Scoreboard bench: a round-robin (MAX_HOLD=4) and a fixed-priority
// arbiter driven side by side, outputs checked on the falling edge.
module tb_bus_arbiter_rr;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] req_fx = '0;
    logic       rsplit = 1'b0;
    logic       sstart = 1'b0;
    logic       sclr = 1'b0;
    logic [1:0] sid = '0;

    logic [3:0] g_rr, g_fx, m_rr, m_fx;
    logic       gs_rr, gs_fx;
    logic [2:0] s_rr, s_fx;

    typedef struct packed {
        int         due;
        logic       which;
        logic [11:0] val;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    cyc = 0;
    int    n_chk = 0;
    int    n_pass = 0;

    bus_arbiter_rr #(
        .NUM_MASTERS (4),
        .RR_MODE     (1),
        .MAX_HOLD    (4)
    ) u_rr (
        .clk            (clk),
        .rst            (rst),
        .req_i          (req),
        .req_split_i    (rsplit),
        .split_start_i  (sstart),
        .split_clr_i    (sclr),
        .split_clr_id_i (sid),
        .grant_o        (g_rr),
        .grant_split_o  (gs_rr),
        .sel_o          (s_rr),
        .split_mask_o   (m_rr)
    );

    bus_arbiter_rr #(
        .NUM_MASTERS (4),
        .RR_MODE     (0),
        .MAX_HOLD    (0)
    ) u_fx (
        .clk            (clk),
        .rst            (rst),
        .req_i          (req_fx),
        .req_split_i    (1'b0),
        .split_start_i  (1'b0),
        .split_clr_i    (1'b0),
        .split_clr_id_i (2'd0),
        .grant_o        (g_fx),
        .grant_split_o  (gs_fx),
        .sel_o          (s_fx),
        .split_mask_o   (m_fx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic expect_out(input string tag, input logic which,
                              input logic [3:0] g, input logic gs,
                              input logic [2:0] s, input logic [3:0] m);
        exp_t e;
        e.due   = cyc + 1;
        e.which = which;
        e.val   = {g, gs, s, m};
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic [3:0] r,
                        input logic [3:0] g, input logic gs,
                        input logic [2:0] s, input logic [3:0] m);
        req = r;
        expect_out(tag, 1'b0, g, gs, s, m);
        tick();
        sstart = 1'b0;
        sclr   = 1'b0;
    endtask

    task automatic fstep(input string tag, input logic [3:0] r,
                         input logic [3:0] g, input logic [2:0] s);
        req_fx = r;
        expect_out(tag, 1'b1, g, 1'b0, s, 4'b0000);
        tick();
    endtask

    // Each expectation is due on the cycle after its stimulus was applied.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            exp_t        e;
            string       t;
            logic [11:0] got;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            if (e.which) got = {g_fx, gs_fx, s_fx, m_fx};
            else         got = {g_rr, gs_rr, s_rr, m_rr};
            check(t, {20'b0, got}, {20'b0, e.val});
        end
    end

    initial begin
        logic [3:0] rk;
        logic [3:0] rn;
        tick();
        expect_out("reset_fx", 1'b1, 4'b0000, 1'b0, 3'd0, 4'b0000);
        step("reset_rr", 4'b1111, 4'b0000, 1'b0, 3'd0, 4'b0000);
        rst = 1'b0;

        for (int k = 0; k < 4; k++) begin
            rk = 4'b1111 << k;
            rn = 4'b1111 << (k + 1);
            step("rr_grant", rk, 4'b0001 << k, 1'b0, 3'(k + 1), 4'b0000);
            step("rr_hold", rk, 4'b0001 << k, 1'b0, 3'(k + 1), 4'b0000);
            step("rr_release", rn, 4'b0000, 1'b0, 3'd0, 4'b0000);
        end

        step("pre_grant", 4'b0001, 4'b0001, 1'b0, 3'd1, 4'b0000);
        step("pre_c0", 4'b0001, 4'b0001, 1'b0, 3'd1, 4'b0000);
        step("pre_c1", 4'b0101, 4'b0001, 1'b0, 3'd1, 4'b0000);
        step("pre_c2", 4'b0101, 4'b0001, 1'b0, 3'd1, 4'b0000);
        step("pre_cut", 4'b0101, 4'b0000, 1'b0, 3'd0, 4'b0000);
        step("pre_next", 4'b0101, 4'b0100, 1'b0, 3'd3, 4'b0000);
        step("pre_end", 4'b0000, 4'b0000, 1'b0, 3'd0, 4'b0000);

        for (int k = 0; k < 7; k++) begin
            step("sat_hold", 4'b1000, 4'b1000, 1'b0, 3'd4, 4'b0000);
        end
        step("sat_end", 4'b0000, 4'b0000, 1'b0, 3'd0, 4'b0000);

        step("spl_grant", 4'b0010, 4'b0010, 1'b0, 3'd2, 4'b0000);
        sstart = 1'b1;
        step("spl_start", 4'b0010, 4'b0000, 1'b0, 3'd0, 4'b0010);
        step("spl_park0", 4'b0010, 4'b0000, 1'b0, 3'd0, 4'b0010);
        step("spl_park1", 4'b0010, 4'b0000, 1'b0, 3'd0, 4'b0010);
        sclr = 1'b1;
        sid  = 2'd1;
        step("spl_clr", 4'b0010, 4'b0000, 1'b0, 3'd0, 4'b0000);
        step("spl_resume", 4'b0010, 4'b0010, 1'b0, 3'd2, 4'b0000);
        step("spl_drop", 4'b0000, 4'b0000, 1'b0, 3'd0, 4'b0000);
        step("sw_grant", 4'b0010, 4'b0010, 1'b0, 3'd2, 4'b0000);
        sstart = 1'b1;
        sclr   = 1'b1;
        step("set_wins", 4'b0010, 4'b0000, 1'b0, 3'd0, 4'b0010);
        sclr = 1'b1;
        step("sw_clr", 4'b0000, 4'b0000, 1'b0, 3'd0, 4'b0000);
        sstart = 1'b1;
        step("start_idle", 4'b0000, 4'b0000, 1'b0, 3'd0, 4'b0000);

        rsplit = 1'b1;
        step("sg_win", 4'b0001, 4'b0000, 1'b1, 3'd0, 4'b0000);
        step("sg_hold", 4'b0001, 4'b0000, 1'b1, 3'd0, 4'b0000);
        rsplit = 1'b0;
        step("sg_gap", 4'b0001, 4'b0000, 1'b0, 3'd0, 4'b0000);
        step("sg_next", 4'b0001, 4'b0001, 1'b0, 3'd1, 4'b0000);
        step("sg_end", 4'b0000, 4'b0000, 1'b0, 3'd0, 4'b0000);

        step("rs_g2", 4'b0100, 4'b0100, 1'b0, 3'd3, 4'b0000);
        sstart = 1'b1;
        step("rs_park", 4'b0100, 4'b0000, 1'b0, 3'd0, 4'b0100);
        step("rs_g1", 4'b0010, 4'b0010, 1'b0, 3'd2, 4'b0100);
        rst = 1'b1;
        step("rs_reset", 4'b1111, 4'b0000, 1'b0, 3'd0, 4'b0000);
        rst = 1'b0;
        step("rs_first", 4'b1111, 4'b0001, 1'b0, 3'd1, 4'b0000);
        step("rs_end", 4'b0000, 4'b0000, 1'b0, 3'd0, 4'b0000);

        fstep("fx_low", 4'b0110, 4'b0010, 3'd2);
        fstep("fx_hold", 4'b0110, 4'b0010, 3'd2);
        fstep("fx_rel", 4'b0100, 4'b0000, 3'd0);
        fstep("fx_next", 4'b0100, 4'b0100, 3'd3);
        fstep("fx_end", 4'b0000, 4'b0000, 3'd0);
        fstep("fx_m0", 4'b1001, 4'b0001, 3'd1);
        fstep("fx_rel0", 4'b1000, 4'b0000, 3'd0);
        fstep("fx_m0_again", 4'b1001, 4'b0001, 3'd1);
        fstep("fx_done", 4'b0000, 4'b0000, 3'd0);

        tick();
        tick();
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
